// File: rtl/mopshub_test_sequencer.sv
// Test-phase sequencer feeding the MOPSHUB data generator.
// Steps through oscillator trim, RX test, end-of-wait pulse, inter-test gap,
// TX test and an optional custom-message test, with a watchdog on every
// phase that waits for an external event.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE    (0) | waiting for start_seq
// TRIM    (1) | oscillator trim requested, waiting for end_power_init
// WAIT_SIGNON (2) | waiting for hub sign-on
// RX      (3) | RX test running, counting test_rx_start pulses
// ENDWAIT (4) | endwait_all pulse cycle, gap counter loaded
// GAP     (5) | fixed inter-test gap
// TX      (6) | TX test running, counting test_tx_start pulses
// ADV     (7) | custom-message test running
// DONE    (8) | sequence finished, holds until start_seq drops
// TIMEOUT (9) | watchdog expired, holds until start_seq drops
module mopshub_test_sequencer #(
  parameter int unsigned GAP_CYCLES     = 120,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter bit          EN_ADV         = 1'b1
) (
  input  logic       clk_40_m,
  input  logic       rst,
  input  logic       start_seq,
  input  logic       trim_en,
  input  logic       end_power_init,
  input  logic       sign_on_sig,
  input  logic       test_rx_start,
  input  logic       test_rx_end,
  input  logic       test_tx_start,
  input  logic       test_tx_end,
  input  logic       costum_msg_end,
  output logic       osc_auto_trim_mopshub,
  output logic       test_rx,
  output logic       test_tx,
  output logic       test_advanced,
  output logic       endwait_all,
  output logic [3:0] seq_state,
  output logic [4:0] rx_bus_cnt,
  output logic [4:0] tx_bus_cnt,
  output logic       seq_done,
  output logic       seq_timeout
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_TRIM        = 4'd1,
    S_WAIT_SIGNON = 4'd2,
    S_RX          = 4'd3,
    S_ENDWAIT     = 4'd4,
    S_GAP         = 4'd5,
    S_TX          = 4'd6,
    S_ADV         = 4'd7,
    S_DONE        = 4'd8,
    S_TIMEOUT     = 4'd9
  } state_t;

  localparam logic [23:0] WDOG_LAST = 24'(TIMEOUT_CYCLES - 1);
  // Loading the full gap value keeps the generator idle for GAP_CYCLES+2
  // edges from the RX end event to test_tx rising.
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES);

  state_t      r_state;
  logic [23:0] r_wdog;
  logic [15:0] r_gap;
  logic [4:0]  r_rx_cnt;
  logic [4:0]  r_tx_cnt;
  logic        r_osc_trim;
  logic        r_test_rx;
  logic        r_test_tx;
  logic        r_test_adv;
  logic        r_endwait;
  logic        r_done;
  logic        r_timeout;

  logic        w_abort;
  logic        w_wdog_state;
  logic        w_phase_end;
  logic        w_wdog_exp;
  logic [4:0]  w_rx_next;
  logic [4:0]  w_tx_next;

  assign w_abort    = !start_seq && (r_state != S_IDLE) &&
                      (r_state != S_DONE) && (r_state != S_TIMEOUT);
  assign w_wdog_exp = (r_wdog == WDOG_LAST);
  assign w_rx_next  = (r_rx_cnt == 5'd31) ? r_rx_cnt : r_rx_cnt + 5'd1;
  assign w_tx_next  = (r_tx_cnt == 5'd31) ? r_tx_cnt : r_tx_cnt + 5'd1;

  // Which states are watched, and which event ends each watched state.
  always_comb begin
    w_wdog_state = 1'b0;
    w_phase_end  = 1'b0;
    case (r_state)
      S_TRIM:        begin w_wdog_state = 1'b1; w_phase_end = end_power_init; end
      S_WAIT_SIGNON: begin w_wdog_state = 1'b1; w_phase_end = sign_on_sig;    end
      S_RX:          begin w_wdog_state = 1'b1; w_phase_end = test_rx_end;    end
      S_TX:          begin w_wdog_state = 1'b1; w_phase_end = test_tx_end;    end
      S_ADV:         begin w_wdog_state = 1'b1; w_phase_end = costum_msg_end; end
      default:       ;
    endcase
  end

  // Sequencer state, watchdog, gap timer, bus counters and registered outputs.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wdog     <= '0;
      r_gap      <= '0;
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_osc_trim <= 1'b0;
      r_test_rx  <= 1'b0;
      r_test_tx  <= 1'b0;
      r_test_adv <= 1'b0;
      r_endwait  <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_abort) begin
      r_state    <= S_IDLE;
      r_wdog     <= '0;
      r_osc_trim <= 1'b0;
      r_test_rx  <= 1'b0;
      r_test_tx  <= 1'b0;
      r_test_adv <= 1'b0;
      r_endwait  <= 1'b0;
    end else if (w_wdog_state && !w_phase_end && w_wdog_exp) begin
      r_state    <= S_TIMEOUT;
      r_wdog     <= '0;
      r_osc_trim <= 1'b0;
      r_test_rx  <= 1'b0;
      r_test_tx  <= 1'b0;
      r_test_adv <= 1'b0;
      r_endwait  <= 1'b0;
      r_timeout  <= 1'b1;
    end else begin
      // Transitions below override this with a clear.
      if (!w_wdog_state || test_rx_start || test_tx_start) r_wdog <= '0;
      else                                                 r_wdog <= r_wdog + 24'd1;

      case (r_state)
        S_IDLE: begin
          if (start_seq) begin
            r_rx_cnt <= '0;
            r_tx_cnt <= '0;
            if (trim_en) begin
              r_osc_trim <= 1'b1;
              r_state    <= S_TRIM;
            end else begin
              r_state    <= S_WAIT_SIGNON;
            end
          end
        end
        S_TRIM: begin
          if (end_power_init) begin
            r_osc_trim <= 1'b0;
            r_state    <= S_WAIT_SIGNON;
            r_wdog     <= '0;
          end
        end
        S_WAIT_SIGNON: begin
          if (sign_on_sig) begin
            r_test_rx <= 1'b1;
            r_state   <= S_RX;
            r_wdog    <= '0;
          end
        end
        S_RX: begin
          if (test_rx_start) r_rx_cnt <= w_rx_next;
          if (test_rx_end) begin
            r_test_rx <= 1'b0;
            r_endwait <= 1'b1;
            r_state   <= S_ENDWAIT;
            r_wdog    <= '0;
          end
        end
        S_ENDWAIT: begin
          r_endwait <= 1'b0;
          r_gap     <= GAP_LOAD;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == 16'd0) begin
            r_test_tx <= 1'b1;
            r_state   <= S_TX;
          end else begin
            r_gap <= r_gap - 16'd1;
          end
        end
        S_TX: begin
          if (test_tx_start) r_tx_cnt <= w_tx_next;
          if (test_tx_end) begin
            r_test_tx <= 1'b0;
            r_wdog    <= '0;
            if (EN_ADV) begin
              r_test_adv <= 1'b1;
              r_state    <= S_ADV;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_ADV: begin
          if (costum_msg_end) begin
            r_test_adv <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
            r_wdog     <= '0;
          end
        end
        S_DONE: begin
          if (!start_seq) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_TIMEOUT: begin
          if (!start_seq) begin
            r_timeout <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_osc_trim <= 1'b0;
          r_test_rx  <= 1'b0;
          r_test_tx  <= 1'b0;
          r_test_adv <= 1'b0;
          r_endwait  <= 1'b0;
          r_done     <= 1'b0;
          r_timeout  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign osc_auto_trim_mopshub = r_osc_trim;
  assign test_rx               = r_test_rx;
  assign test_tx               = r_test_tx;
  assign test_advanced         = r_test_adv;
  assign endwait_all           = r_endwait;
  assign seq_state             = r_state;
  assign rx_bus_cnt            = r_rx_cnt;
  assign tx_bus_cnt            = r_tx_cnt;
  assign seq_done              = r_done;
  assign seq_timeout           = r_timeout;

endmodule
